// File: rtl/freespace_update_arbiter_pkg.sv
// Shared constants and helpers for the freespace-update port clusters.
// Default widths, packet slicing and index sizing.
package freespace_update_arbiter_pkg;

  localparam int DEF_PACKET_BITS  = 97;
  localparam int DEF_NUM_IN_PORTS = 7;
  localparam int DEF_CNT_BITS     = 16;

  function automatic int pkt_lsb(
    input int port,
    input int bits
  );
    return port * bits;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freespace_update_arbiter_if.sv
// Packet valid/ack handshake toward the leaf interface.
// master: pkt, vld out / ack in; slave: the consumer side.
interface freespace_update_arbiter_if
  import freespace_update_arbiter_pkg::*;
#(
  parameter int PACKET_BITS = DEF_PACKET_BITS
) ();

  logic [PACKET_BITS-1:0] pkt;
  logic                   vld;
  logic                   ack;

  modport master (
    output pkt,
    output vld,
    input  ack
  );

  modport slave (
    input  pkt,
    input  vld,
    output ack
  );

endinterface

// File: rtl/freespace_update_arbiter_rr.sv
// Combinational round-robin picker: req_i, last_i in;
// one-hot gnt_o and encoded idx_o out, search starts after last_i.
module rr_arbiter #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   p;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(last_i) + k) % N;
      if (!found && req_i[p]) begin
        found    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = IW'(p);
      end
    end
  end

endmodule

// File: rtl/freespace_update_arbiter.sv
// Coalescing freespace-update arbiter: per-port hold regs + pending,
// round-robin issue into one registered pkt_out/vld/ack slot.
module freespace_update_arbiter
  import freespace_update_arbiter_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int NUM_IN_PORTS = DEF_NUM_IN_PORTS,
  parameter int CNT_BITS     = DEF_CNT_BITS
) (
  input  logic                                clk_bft,
  input  logic                                reset_bft,
  input  logic [NUM_IN_PORTS-1:0]             freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
  output logic [PACKET_BITS-1:0]              pkt_out,
  output logic                                pkt_out_vld,
  input  logic                                pkt_out_ack,
  output logic [NUM_IN_PORTS-1:0]             pending,
  output logic [CNT_BITS-1:0]                 coalesce_cnt
);

  localparam int IW = idx_bits(NUM_IN_PORTS);
  localparam int SW = CNT_BITS + IW + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_IN_PORTS - 1);

  logic [PACKET_BITS-1:0]  hold_q [NUM_IN_PORTS];
  logic [PACKET_BITS-1:0]  hold_d [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0] pend_q, pend_d;
  logic [PACKET_BITS-1:0]  pkt_q, pkt_d;
  logic                    vld_q, vld_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]           last_q, last_d;

  logic [NUM_IN_PORTS-1:0] gnt, take, coal;
  logic [IW-1:0]           gidx;
  logic                    slot_free, any_pend, grant_en;
  logic [SW-1:0]           inc, sum;

  rr_arbiter #(
    .N  (NUM_IN_PORTS),
    .IW (IW)
  ) u_rr (
    .req_i  (pend_q),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gidx)
  );

  always_comb begin
    slot_free = !vld_q || pkt_out_ack;
    any_pend  = |pend_q;
    grant_en  = slot_free && any_pend;
    take      = grant_en ? gnt : '0;
    // a pulse on the port being granted this edge refills, not coalesces
    coal      = freespace_update & pend_q & ~take;
    pend_d    = (pend_q & ~take) | freespace_update;

    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      hold_d[i] = freespace_update[i]
        ? packet_from_input_ports[pkt_lsb(i, PACKET_BITS) +: PACKET_BITS]
        : hold_q[i];
    end

    inc = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      inc = inc + SW'(coal[i]);
    end
    sum   = SW'(cnt_q) + inc;
    cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_BITS-1:0];

    pkt_d  = pkt_q;
    vld_d  = vld_q;
    last_d = last_q;
    unique case (1'b1)
      grant_en: begin
        pkt_d  = hold_q[gidx];
        vld_d  = 1'b1;
        last_d = gidx;
      end
      slot_free && !any_pend: begin
        vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      pend_q <= '0;
      pkt_q  <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      last_q <= LAST_RST;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      pkt_q  <= pkt_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign pkt_out      = pkt_q;
  assign pkt_out_vld  = vld_q;
  assign pending      = pend_q;
  assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_freespace_update_arbiter.sv
// Directed bench for freespace_update_arbiter with a cycle model.
// Model checked every cycle; literal checks pin the scenarios.
module tb_freespace_update_arbiter;

  localparam int PB = 97;
  localparam int NP = 7;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pulse;
  logic [PB*NP-1:0] pkts;
  logic [NP-1:0] pend;
  logic [CB-1:0] cnt;

  freespace_update_arbiter_if #(.PACKET_BITS(PB)) oif ();

  always #5 clk = ~clk;

  freespace_update_arbiter #(
    .PACKET_BITS  (PB),
    .NUM_IN_PORTS (NP),
    .CNT_BITS     (CB)
  ) dut (
    .clk_bft                 (clk),
    .reset_bft               (rst),
    .freespace_update        (pulse),
    .packet_from_input_ports (pkts),
    .pkt_out                 (oif.pkt),
    .pkt_out_vld             (oif.vld),
    .pkt_out_ack             (oif.ack),
    .pending                 (pend),
    .coalesce_cnt            (cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [PB-1:0] m_hold [NP];
  logic [NP-1:0] m_pend;
  logic [PB-1:0] m_pkt;
  logic          m_vld;
  logic [CB-1:0] m_cnt;
  int            m_last;

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  function automatic logic [PB-1:0] in_pkt(input int i);
    return pkts[i*PB +: PB];
  endfunction

  // Spec-level cycle model: decide the grant from the old state,
  // then apply the pulses.
  task automatic model_step();
    logic [NP-1:0] pend0;
    logic          free;
    int            g;
    pend0 = m_pend;
    free  = !m_vld || oif.ack;
    g     = -1;
    if (rst) begin
      m_pend = '0;
      m_pkt  = '0;
      m_vld  = 1'b0;
      m_cnt  = '0;
      m_last = NP - 1;
      for (int i = 0; i < NP; i++) m_hold[i] = '0;
    end else begin
      if (free && (m_pend != '0)) begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (m_last + k) % NP;
          if (g < 0 && m_pend[p]) g = p;
        end
        m_pkt     = m_hold[g];
        m_vld     = 1'b1;
        m_pend[g] = 1'b0;
        m_last    = g;
      end else if (free) begin
        m_vld = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
        if (pulse[i]) begin
          if (pend0[i] && i != g && m_cnt != '1) m_cnt = m_cnt + 1'b1;
          m_hold[i] = in_pkt(i);
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("vld", 128'(oif.vld), 128'(m_vld));
    chk("pending", 128'(pend), 128'(m_pend));
    chk("cnt", 128'(cnt), 128'(m_cnt));
    if (m_vld) chk("pkt", 128'(oif.pkt), 128'(m_pkt));
  endtask

  task automatic set_pkt(input int i, input logic [PB-1:0] v);
    pkts[i*PB +: PB] = v;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pulse = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    pulse   = '0;
    pkts    = '0;
    oif.ack = 1'b0;
    m_last  = NP - 1;

    // reset state
    tick();
    tick();
    chk("rst_vld", 128'(oif.vld), 128'h0);
    chk("rst_pkt", 128'(oif.pkt), 128'h0);
    chk("rst_pend", 128'(pend), 128'h0);
    chk("rst_cnt", 128'(cnt), 128'h0);
    rst = 1'b0;

    // single pulse, port 3, latency 2
    oif.ack = 1'b1;
    set_pkt(3, 97'h1A5);
    pulse = 7'b0001000;
    tick();
    pulse = '0;
    chk("p3_pend", 128'(pend), 128'h08);
    chk("p3_vld_early", 128'(oif.vld), 128'h0);
    tick();
    chk("p3_vld", 128'(oif.vld), 128'h1);
    chk("p3_pkt", 128'(oif.pkt), 128'h1A5);
    tick();
    chk("p3_vld_off", 128'(oif.vld), 128'h0);
    chk("p3_pend_off", 128'(pend), 128'h0);

    // all ports at once, issued 0..6 back to back
    do_reset();
    oif.ack = 1'b1;
    for (int i = 0; i < NP; i++) set_pkt(i, PB'(32'h100 + i));
    pulse = '1;
    tick();
    pulse = '0;
    for (int k = 0; k < NP; k++) begin
      tick();
      chk("all_vld", 128'(oif.vld), 128'h1);
      chk("all_pkt", 128'(oif.pkt), 128'(32'h100 + k));
    end
    chk("all_cnt", 128'(cnt), 128'h0);
    tick();
    chk("all_done", 128'(oif.vld), 128'h0);

    // stall + coalesce: port 2 gets A, B, C while slot is held
    do_reset();
    oif.ack = 1'b0;
    set_pkt(0, 97'hBEEF);
    pulse = 7'b0000001;
    tick();
    pulse = '0;
    tick();
    chk("stall_pkt0", 128'(oif.pkt), 128'hBEEF);
    for (int k = 0; k < 5; k++) begin
      pulse = '0;
      if (k < 3) begin
        set_pkt(2, PB'(32'hA0 + k));
        pulse = 7'b0000100;
      end
      tick();
      chk("stall_hold", 128'(oif.pkt), 128'hBEEF);
      chk("stall_vld", 128'(oif.vld), 128'h1);
    end
    pulse = '0;
    chk("coal_cnt", 128'(cnt), 128'h2);
    oif.ack = 1'b1;
    tick();
    chk("coal_pkt", 128'(oif.pkt), 128'hA2);
    chk("coal_pend", 128'(pend), 128'h0);
    tick();
    chk("coal_once", 128'(oif.vld), 128'h0);
    chk("coal_cnt2", 128'(cnt), 128'h2);

    // grant and pulse on port 1 in the same cycle
    do_reset();
    oif.ack = 1'b1;
    set_pkt(1, 97'h111);
    pulse = 7'b0000010;
    tick();
    set_pkt(1, 97'hD0D);
    tick();
    pulse = '0;
    chk("same_pkt", 128'(oif.pkt), 128'h111);
    chk("same_pend", 128'(pend), 128'h02);
    chk("same_cnt", 128'(cnt), 128'h0);
    tick();
    chk("same_next", 128'(oif.pkt), 128'hD0D);
    chk("same_vld", 128'(oif.vld), 128'h1);
    tick();
    chk("same_cnt2", 128'(cnt), 128'h0);

    // reset mid-operation, then port 0 wins over port 5
    do_reset();
    oif.ack = 1'b0;
    for (int i = 1; i <= 4; i++) set_pkt(i, PB'(32'h50 + i));
    set_pkt(6, 97'h56);
    pulse = 7'b0011110;
    tick();
    pulse = 7'b1000000;
    tick();
    chk("mid_pkt", 128'(oif.pkt), 128'h51);
    chk("mid_pend", 128'(pend), 128'h5C);
    rst     = 1'b1;
    pulse   = 7'b0100000;
    oif.ack = 1'b1;
    tick();
    rst   = 1'b0;
    pulse = '0;
    chk("mr_vld", 128'(oif.vld), 128'h0);
    chk("mr_pkt", 128'(oif.pkt), 128'h0);
    chk("mr_pend", 128'(pend), 128'h0);
    chk("mr_cnt", 128'(cnt), 128'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_quiet", 128'(oif.vld), 128'h0);
    end
    set_pkt(0, 97'hA0);
    set_pkt(5, 97'hA5);
    pulse = 7'b0100001;
    tick();
    pulse = '0;
    tick();
    chk("mr_first", 128'(oif.pkt), 128'hA0);
    tick();
    chk("mr_second", 128'(oif.pkt), 128'hA5);
    tick();
    chk("mr_idle", 128'(oif.vld), 128'h0);

    // counter saturation with every port coalescing each cycle
    do_reset();
    oif.ack = 1'b0;
    for (int c = 0; c < 9400; c++) begin
      for (int i = 0; i < NP; i++) set_pkt(i, PB'(i * 100000 + c));
      pulse = '1;
      tick();
    end
    chk("sat_cnt", 128'(cnt), 128'hFFFF);
    tick();
    pulse = '0;
    chk("sat_hold", 128'(cnt), 128'hFFFF);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
